// File: rtl/params_pkg.sv
// Shared types and constants for the memory request arbiter slice.
// Optional watchdog support is controlled by the MEM_ARB_TIMEOUT_EN macro
// (used by mem_port_tracker and mem_req_arbiter).
package params_pkg;

    // Byte address width of the memory interface.
    localparam int ADDR_WIDTH = 32;

    // Memory cycles from a request being sampled to data_valid.
    localparam int MEM_LATENCY = 10;

    // Access size encoding understood by the memory.
    typedef enum logic [2:0] {
        SIZE_BYTE  = 3'd0,
        SIZE_HALF  = 3'd1,
        SIZE_WORD  = 3'd2,
        SIZE_DWORD = 3'd3,
        SIZE_LINE  = 3'd4
    } access_size_t;

    // Fetch requests always move a whole line.
    localparam access_size_t LINE_ACCESS = SIZE_LINE;

    // Per-port read tracking state.
    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_RESP = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mem_port_tracker.sv
// Per-port read tracker: IDLE/WAIT_RESP state, response capture, and a
// filter that drops responses arriving while no read is outstanding.
// With MEM_ARB_TIMEOUT_EN defined, a watchdog abandons a read that has
// waited TIMEOUT_CYCLES and reports it through the timeout output.
module mem_port_tracker
    import params_pkg::*;
#(
    parameter int DATA_WIDTH = 128
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 32
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_accept,
    input  logic                  rsp_hit,
    input  logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  idle,
    output logic                  resp_valid,
`ifdef MEM_ARB_TIMEOUT_EN
    output logic                  timeout,
`endif
    output logic [DATA_WIDTH-1:0] resp_data
);

    arb_state_t state;
    logic       expire;

    assign idle = (state == IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_cnt;

    // A response arriving in the final cycle still wins over the watchdog.
    assign expire  = (state == WAIT_RESP) && !rsp_hit &&
                     (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign timeout = expire;

    // Count cycles spent waiting; restart from zero on every new wait.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == WAIT_RESP) begin
            wait_cnt <= wait_cnt + CW'(1);
        end else begin
            wait_cnt <= '0;
        end
    end
`else
    assign expire = 1'b0;
`endif

    // Port FSM with registered response outputs; responses seen in IDLE are discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_data  <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (rd_accept) begin
                        state <= WAIT_RESP;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT_RESP: begin
                    if (rsp_hit) begin
                        state      <= IDLE;
                        resp_valid <= 1'b1;
                        resp_data  <= rsp_data;
                    end else if (expire) begin
                        state <= IDLE;
                    end else begin
                        state <= WAIT_RESP;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Initiator-side front end for the fixed-latency pipelined memory.
// Round-robin arbitration between the fetch port (read-only) and the data
// port, registered memory-side request outputs, and tag-based routing of
// returning lines. Define MEM_ARB_TIMEOUT_EN to enable the per-port
// read watchdog and the sticky timeout_err_o flag.
module mem_req_arbiter #(
    parameter int ADDR_WIDTH     = params_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH     = 128,
    parameter int MEM_LATENCY    = params_pkg::MEM_LATENCY,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     if_req_valid_i,
    output logic                     if_req_ready_o,
    input  logic [ADDR_WIDTH-1:0]    if_req_addr_i,
    output logic                     if_resp_valid_o,
    output logic [DATA_WIDTH-1:0]    if_resp_data_o,
    input  logic                     dc_req_valid_i,
    output logic                     dc_req_ready_o,
    input  logic                     dc_req_wr_i,
    input  logic [ADDR_WIDTH-1:0]    dc_req_addr_i,
    input  params_pkg::access_size_t dc_req_size_i,
    input  logic [DATA_WIDTH-1:0]    dc_req_wdata_i,
    output logic                     dc_resp_valid_o,
    output logic [DATA_WIDTH-1:0]    dc_resp_data_o,
    output logic                     rd_req_valid_o,
    output logic                     wr_req_valid_o,
    output logic                     req_is_instr_o,
    output logic [ADDR_WIDTH-1:0]    address_o,
    output logic [DATA_WIDTH-1:0]    wr_data_o,
    output params_pkg::access_size_t access_size_o,
    input  logic                     data_valid_i,
    input  logic                     data_is_instr_i,
    input  logic [DATA_WIDTH-1:0]    data_i,
    output logic                     timeout_err_o
);

    import params_pkg::*;

    // The watchdog must never fire on a healthy read.
    if (TIMEOUT_CYCLES <= MEM_LATENCY + 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must exceed MEM_LATENCY+2");
    end

    logic if_idle;
    logic dc_idle;
    logic if_elig;
    logic dc_elig;
    logic grant_if;
    logic grant_dc;
    logic favor_dc;
    logic if_hit;
    logic dc_hit;
`ifdef MEM_ARB_TIMEOUT_EN
    logic if_to;
    logic dc_to;
`endif

    // Nothing is accepted while reset is held, so no handshake is lost to it.
    assign if_elig = if_req_valid_i & if_idle & ~rst_i;
    assign dc_elig = dc_req_valid_i & dc_idle & ~rst_i;

    // Round-robin choice between the eligible ports.
    always_comb begin
        grant_if = 1'b0;
        grant_dc = 1'b0;
        if (if_elig && dc_elig) begin
            if (favor_dc) begin
                grant_dc = 1'b1;
            end else begin
                grant_if = 1'b1;
            end
        end else if (dc_elig) begin
            grant_dc = 1'b1;
        end else if (if_elig) begin
            grant_if = 1'b1;
        end else begin
            grant_if = 1'b0;
            grant_dc = 1'b0;
        end
    end

    assign if_req_ready_o = grant_if;
    assign dc_req_ready_o = grant_dc;

    // Register the granted request toward memory and flip the priority pointer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            favor_dc       <= 1'b1;
            rd_req_valid_o <= 1'b0;
            wr_req_valid_o <= 1'b0;
            req_is_instr_o <= 1'b0;
            address_o      <= '0;
            wr_data_o      <= '0;
            access_size_o  <= SIZE_BYTE;
        end else if (grant_if) begin
            favor_dc       <= 1'b1;
            rd_req_valid_o <= 1'b1;
            wr_req_valid_o <= 1'b0;
            req_is_instr_o <= 1'b1;
            address_o      <= if_req_addr_i;
            access_size_o  <= LINE_ACCESS;
        end else if (grant_dc) begin
            favor_dc       <= 1'b0;
            rd_req_valid_o <= ~dc_req_wr_i;
            wr_req_valid_o <= dc_req_wr_i;
            req_is_instr_o <= 1'b0;
            address_o      <= dc_req_addr_i;
            wr_data_o      <= dc_req_wdata_i;
            access_size_o  <= dc_req_size_i;
        end else begin
            rd_req_valid_o <= 1'b0;
            wr_req_valid_o <= 1'b0;
        end
    end

    // Route each returning line by its tag.
    assign if_hit = data_valid_i &  data_is_instr_i;
    assign dc_hit = data_valid_i & ~data_is_instr_i;

    mem_port_tracker #(
        .DATA_WIDTH     (DATA_WIDTH)
`ifdef MEM_ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`endif
    ) u_if_trk (
        .clk        (clk_i),
        .rst        (rst_i),
        .rd_accept  (grant_if),
        .rsp_hit    (if_hit),
        .rsp_data   (data_i),
        .idle       (if_idle),
        .resp_valid (if_resp_valid_o),
`ifdef MEM_ARB_TIMEOUT_EN
        .timeout    (if_to),
`endif
        .resp_data  (if_resp_data_o)
    );

    mem_port_tracker #(
        .DATA_WIDTH     (DATA_WIDTH)
`ifdef MEM_ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`endif
    ) u_dc_trk (
        .clk        (clk_i),
        .rst        (rst_i),
        .rd_accept  (grant_dc & ~dc_req_wr_i),
        .rsp_hit    (dc_hit),
        .rsp_data   (data_i),
        .idle       (dc_idle),
        .resp_valid (dc_resp_valid_o),
`ifdef MEM_ARB_TIMEOUT_EN
        .timeout    (dc_to),
`endif
        .resp_data  (dc_resp_data_o)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    // Sticky watchdog flag, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timeout_err_o <= 1'b0;
        end else if (if_to || dc_to) begin
            timeout_err_o <= 1'b1;
        end else begin
            timeout_err_o <= timeout_err_o;
        end
    end
`else
    assign timeout_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: a memory stub answers reads after
// MEM_LATENCY cycles, and a transaction-level model predicts grants,
// memory requests and response pulses from the port-level rules.
module tb_mem_req_arbiter;
    import params_pkg::*;

    localparam int AW  = 32;
    localparam int DW  = 128;
    localparam int TO  = 32;
    localparam int NEVER = 32'h7fffffff;

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic            if_req_valid_i = 1'b0;
    logic            if_req_ready_o;
    logic [AW-1:0]   if_req_addr_i = '0;
    logic            if_resp_valid_o;
    logic [DW-1:0]   if_resp_data_o;
    logic            dc_req_valid_i = 1'b0;
    logic            dc_req_ready_o;
    logic            dc_req_wr_i = 1'b0;
    logic [AW-1:0]   dc_req_addr_i = '0;
    access_size_t    dc_req_size_i = SIZE_BYTE;
    logic [DW-1:0]   dc_req_wdata_i = '0;
    logic            dc_resp_valid_o;
    logic [DW-1:0]   dc_resp_data_o;
    logic            rd_req_valid_o;
    logic            wr_req_valid_o;
    logic            req_is_instr_o;
    logic [AW-1:0]   address_o;
    logic [DW-1:0]   wr_data_o;
    access_size_t    access_size_o;
    logic            data_valid_i;
    logic            data_is_instr_i;
    logic [DW-1:0]   data_i;
    logic            timeout_err_o;

    always #5 clk = ~clk;

    mem_req_arbiter dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .if_req_valid_i  (if_req_valid_i),
        .if_req_ready_o  (if_req_ready_o),
        .if_req_addr_i   (if_req_addr_i),
        .if_resp_valid_o (if_resp_valid_o),
        .if_resp_data_o  (if_resp_data_o),
        .dc_req_valid_i  (dc_req_valid_i),
        .dc_req_ready_o  (dc_req_ready_o),
        .dc_req_wr_i     (dc_req_wr_i),
        .dc_req_addr_i   (dc_req_addr_i),
        .dc_req_size_i   (dc_req_size_i),
        .dc_req_wdata_i  (dc_req_wdata_i),
        .dc_resp_valid_o (dc_resp_valid_o),
        .dc_resp_data_o  (dc_resp_data_o),
        .rd_req_valid_o  (rd_req_valid_o),
        .wr_req_valid_o  (wr_req_valid_o),
        .req_is_instr_o  (req_is_instr_o),
        .address_o       (address_o),
        .wr_data_o       (wr_data_o),
        .access_size_o   (access_size_o),
        .data_valid_i    (data_valid_i),
        .data_is_instr_i (data_is_instr_i),
        .data_i          (data_i),
        .timeout_err_o   (timeout_err_o)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory stub ----------------
    logic [7:0]    stub_mem [int];
    bit            sch_v [64];
    bit            sch_i [64];
    logic [DW-1:0] sch_d [64];
    bit            silent = 1'b0;
    int            inj_cyc = -1;
    bit            inj_instr = 1'b0;

    function automatic logic [DW-1:0] stub_line(input logic [AW-1:0] a);
        logic [DW-1:0] l;
        logic [AW-1:0] b;
        for (int i = 0; i < 16; i++) begin
            b = a + AW'(i);
            l[8*i +: 8] = stub_mem.exists(int'(b)) ? stub_mem[int'(b)] : b[7:0];
        end
        return l;
    endfunction

    initial begin
        int k;
        data_valid_i    = 1'b0;
        data_is_instr_i = 1'b0;
        data_i          = '0;
        forever begin
            @(negedge clk);
            if (wr_req_valid_o) begin
                for (int i = 0; i < 16; i++)
                    stub_mem[int'(address_o + AW'(i))] = wr_data_o[8*i +: 8];
            end
            if (rd_req_valid_o && !silent) begin
                k = (cyc + MEM_LATENCY) % 64;
                sch_v[k] = 1'b1;
                sch_i[k] = req_is_instr_o;
                sch_d[k] = stub_line(address_o);
            end
            k = cyc % 64;
            data_valid_i    = sch_v[k];
            data_is_instr_i = sch_i[k];
            data_i          = sch_d[k];
            sch_v[k]        = 1'b0;
            if (cyc == inj_cyc) begin
                data_valid_i    = 1'b1;
                data_is_instr_i = inj_instr;
                data_i          = {4{32'hDEADBEEF}};
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0]    ref_mem [int];
    int            if_free, dc_free;
    bit            favor_dc;
    int            if_exp_cyc, dc_exp_cyc, err_cyc;
    logic [DW-1:0] if_exp_data, dc_exp_data, if_last, dc_last;
    bit            exp_rd, exp_wr, exp_instr;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    access_size_t  exp_size;

    function automatic logic [DW-1:0] ref_line(input logic [AW-1:0] a);
        logic [DW-1:0] l;
        logic [AW-1:0] b;
        for (int i = 0; i < 16; i++) begin
            b = a + AW'(i);
            l[8*i +: 8] = ref_mem.exists(int'(b)) ? ref_mem[int'(b)] : b[7:0];
        end
        return l;
    endfunction

    task automatic model_reset();
        if_free = 0; dc_free = 0; favor_dc = 1'b1;
        if_exp_cyc = -1; dc_exp_cyc = -1; err_cyc = NEVER;
        if_last = '0; dc_last = '0;
        exp_rd = 1'b0; exp_wr = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        bit ev;
        chk("rd_req_valid", DW'(rd_req_valid_o), DW'(exp_rd));
        chk("wr_req_valid", DW'(wr_req_valid_o), DW'(exp_wr));
        if (exp_rd || exp_wr) begin
            chk("req_is_instr", DW'(req_is_instr_o), DW'(exp_instr));
            chk("address", DW'(address_o), DW'(exp_addr));
            chk("access_size", DW'(access_size_o), DW'(exp_size));
        end
        if (exp_wr) chk("wr_data", wr_data_o, exp_wdata);
        ev = (cyc == if_exp_cyc);
        chk("if_resp_valid", DW'(if_resp_valid_o), DW'(ev));
        if (ev) if_last = if_exp_data;
        chk("if_resp_data", if_resp_data_o, if_last);
        ev = (cyc == dc_exp_cyc);
        chk("dc_resp_valid", DW'(dc_resp_valid_o), DW'(ev));
        if (ev) dc_last = dc_exp_data;
        chk("dc_resp_data", dc_resp_data_o, dc_last);
`ifdef MEM_ARB_TIMEOUT_EN
        chk("timeout_err", DW'(timeout_err_o), DW'(cyc >= err_cyc));
`else
        chk("timeout_err", DW'(timeout_err_o), DW'(1'b0));
`endif
    endtask

    // One clock: check outputs, apply inputs, predict and check the grant.
    task automatic cycle(input logic ifv, input logic [AW-1:0] ifa,
                         input logic dcv, input logic dcw, input logic [AW-1:0] dca,
                         input access_size_t dcs, input logic [DW-1:0] dcd);
        bit ife, dce, gi, gd;
        @(negedge clk);
        check_outputs();
        if_req_valid_i = ifv; if_req_addr_i = ifa;
        dc_req_valid_i = dcv; dc_req_wr_i = dcw; dc_req_addr_i = dca;
        dc_req_size_i = dcs; dc_req_wdata_i = dcd;
        #1;
        ife = ifv && (cyc >= if_free);
        dce = dcv && (cyc >= dc_free);
        gi  = ife && (!dce || !favor_dc);
        gd  = dce && (!ife || favor_dc);
        chk("if_req_ready", DW'(if_req_ready_o), DW'(gi));
        chk("dc_req_ready", DW'(dc_req_ready_o), DW'(gd));
        exp_rd = 1'b0; exp_wr = 1'b0;
        if (gi) begin
            favor_dc = 1'b1;
            exp_rd = 1'b1; exp_instr = 1'b1; exp_addr = ifa; exp_size = LINE_ACCESS;
            if (silent) begin
                if_free = cyc + 1 + TO;
                if (err_cyc > if_free) err_cyc = if_free;
            end else begin
                if_free = cyc + MEM_LATENCY + 2;
                if_exp_cyc = if_free;
                if_exp_data = ref_line(ifa);
            end
        end else if (gd) begin
            favor_dc = 1'b0;
            exp_instr = 1'b0; exp_addr = dca; exp_size = dcs;
            if (dcw) begin
                exp_wr = 1'b1; exp_wdata = dcd;
                for (int i = 0; i < 16; i++) ref_mem[int'(dca + AW'(i))] = dcd[8*i +: 8];
            end else begin
                exp_rd = 1'b1;
                dc_free = cyc + MEM_LATENCY + 2;
                dc_exp_cyc = dc_free;
                dc_exp_data = ref_line(dca);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, '0, 1'b0, 1'b0, '0, SIZE_BYTE, '0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_i = 1'b1; if_req_valid_i = 1'b1; dc_req_valid_i = 1'b1; dc_req_wr_i = 1'b0;
        repeat (n) begin
            @(negedge clk);
            #1;
            chk("rst_ready", DW'({if_req_ready_o, dc_req_ready_o}), DW'(2'b00));
            chk("rst_req", DW'({rd_req_valid_o, wr_req_valid_o, req_is_instr_o, timeout_err_o}), DW'(4'b0000));
            chk("rst_addr_size", DW'({address_o, access_size_o}), DW'(35'd0));
            chk("rst_wr_data", wr_data_o, '0);
            chk("rst_resp_valid", DW'({if_resp_valid_o, dc_resp_valid_o}), DW'(2'b00));
            chk("rst_if_data", if_resp_data_o, '0);
            chk("rst_dc_data", dc_resp_data_o, '0);
        end
        rst_i = 1'b0; if_req_valid_i = 1'b0; dc_req_valid_i = 1'b0;
        silent = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [DW-1:0] a5;
        a5 = {16{8'hA5}};
        model_reset();
        do_reset(2);

        // single fetch read of line 0x40
        cycle(1'b1, 32'h40, 1'b0, 1'b0, '0, SIZE_BYTE, '0);
        idle(13);

        // simultaneous requests after reset: data port first, then fetch
        do_reset(1);
        cycle(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, SIZE_WORD, '0);
        cycle(1'b1, 32'h100, 1'b0, 1'b0, '0, SIZE_BYTE, '0);
        idle(13);

        // posted write then read of the same line
        cycle(1'b0, '0, 1'b1, 1'b1, 32'h80, SIZE_LINE, a5);
        cycle(1'b0, '0, 1'b1, 1'b0, 32'h80, SIZE_WORD, '0);
        idle(13);

        // second fetch request held while the first is outstanding
        cycle(1'b1, 32'h40, 1'b0, 1'b0, '0, SIZE_BYTE, '0);
        repeat (12) cycle(1'b1, 32'h50, 1'b0, 1'b0, '0, SIZE_BYTE, '0);
        idle(13);

        // spurious data response while the data port is idle
        inj_instr = 1'b0;
        inj_cyc = cyc + 2;
        idle(4);
        cycle(1'b0, '0, 1'b1, 1'b0, 32'h30, SIZE_HALF, '0);
        idle(13);

        // reset while a fetch read is in flight; its late response is dropped
        cycle(1'b1, 32'h60, 1'b0, 1'b0, '0, SIZE_BYTE, '0);
        idle(5);
        do_reset(1);
        idle(14);

`ifdef MEM_ARB_TIMEOUT_EN
        // silent memory: watchdog fires, port usable again, then reset mid-wait
        silent = 1'b1;
        cycle(1'b1, 32'h70, 1'b0, 1'b0, '0, SIZE_BYTE, '0);
        repeat (TO + 1) cycle(1'b1, 32'h90, 1'b0, 1'b0, '0, SIZE_BYTE, '0);
        do_reset(1);
        idle(2);
`endif

        // randomized traffic on both ports
        for (int n = 0; n < 400; n++) begin
            cycle(1'($urandom_range(0, 1)), AW'({$urandom_range(0, 15), 4'h0}),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  AW'({$urandom_range(0, 15), 4'h0}),
                  access_size_t'(3'($urandom_range(0, 4))),
                  {$urandom, $urandom, $urandom, $urandom});
        end
        idle(14);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Initiator-side front end for the fixed-latency pipelined memory.
- Accepts line requests from the instruction-fetch port and the data port, which both speak valid/ready.
- Arbitrates between the two ports and drives at most one memory request per cycle.
- Tracks one outstanding read per port and routes each returning line to its owner using the is_instr tag.
- Writes are posted: the memory returns no response for them.

Parameters:
- ADDR_WIDTH, params_pkg::ADDR_WIDTH, byte address width.
- DATA_WIDTH, 128, line width in bits.
- MEM_LATENCY, 10, memory cycles from request sampled to data_valid.
- TIMEOUT_CYCLES, 32, watchdog limit per outstanding read (feature only). Must be greater than MEM_LATENCY+2.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset; synchronous, active-high.
- if_req_valid_i  in  1  fetch read request.
- if_req_ready_o  out  1  fetch request accepted this cycle.
- if_req_addr_i  in  ADDR_WIDTH  fetch line address.
- if_resp_valid_o  out  1  fetch line returned; one-cycle pulse.
- if_resp_data_o  out  DATA_WIDTH  fetch line data.
- dc_req_valid_i  in  1  data request.
- dc_req_ready_o  out  1  data request accepted this cycle.
- dc_req_wr_i  in  1  1 = write, 0 = read.
- dc_req_addr_i  in  ADDR_WIDTH  data address.
- dc_req_size_i  in  access_size_t  access size.
- dc_req_wdata_i  in  DATA_WIDTH  write data.
- dc_resp_valid_o  out  1  data read returned; one-cycle pulse.
- dc_resp_data_o  out  DATA_WIDTH  data read line.
- rd_req_valid_o  out  1  to memory.
- wr_req_valid_o  out  1  to memory.
- req_is_instr_o  out  1  to memory.
- address_o  out  ADDR_WIDTH  to memory.
- wr_data_o  out  DATA_WIDTH  to memory.
- access_size_o  out  access_size_t  to memory.
- data_valid_i  in  1  from memory.
- data_is_instr_i  in  1  from memory.
- data_i  in  DATA_WIDTH  from memory.
- timeout_err_o  out  1  sticky watchdog error (feature only).

Behaviour:
- Reset: all outputs 0, both port FSMs IDLE, round-robin pointer favours the data port.
- Per-port FSM:
  - IDLE --read handshake--> WAIT_RESP.
  - WAIT_RESP --matching data_valid_i--> IDLE.
  - Writes never leave IDLE.
- Eligibility: a port is eligible when its valid is high and its FSM is IDLE. The fetch port is read-only, so it is always IDLE or WAIT_RESP.
- Arbitration: combinational, round-robin between the two eligible ports.
  - The winner gets ready=1 in the same cycle; the loser gets ready=0.
  - The pointer flips to the other port after every grant.
- Memory-side outputs are registered. A handshake in cycle T drives exactly one cycle of rd_req_valid_o or wr_req_valid_o in cycle T+1, with that request's addr, data, size and is_instr. All valids return to 0 when no grant occurs.
- Fetch requests drive req_is_instr_o=1 and access_size_o = full-line encoding; data requests drive 0 and dc_req_size_i.
- Response routing: data_valid_i is registered into resp_valid/resp_data.
  - data_is_instr_i=1 goes to the fetch port; 0 goes to the data port.
  - Response pulse appears in cycle T+MEM_LATENCY+2, i.e. 12 cycles after the handshake.
- Spurious response (owner FSM is IDLE): dropped, no pulse, no state change.
- A port's ready is 0 throughout WAIT_RESP. The next request is accepted at the earliest in the cycle its resp_valid pulses, since the FSM returns to IDLE at the same edge.
- Ordering: the memory is in-order. A write followed by a read to the same address returns the written data; no hazard logic is needed.
- Reset mid-operation: FSMs return to IDLE. Responses still in flight from the memory after reset are dropped as spurious.
- Response data outputs hold their last value when valid is 0.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- With the macro: each port has a cycle counter that counts while its FSM is in WAIT_RESP. When the count reaches TIMEOUT_CYCLES:
  - timeout_err_o sets and stays set until reset;
  - the FSM returns to IDLE;
  - a late response for that read is dropped as spurious.
- Without the macro: no counters, and timeout_err_o is tied to 0.

Decomposition:
- params_pkg gains:
  - arb_state_t (IDLE, WAIT_RESP);
  - the MEM_LATENCY constant;
  - a LINE_ACCESS constant of type access_size_t.
- The existing access_size_t is reused.
- One natural sub-module is mem_port_tracker, instantiated twice: the per-port FSM, spurious filter and optional watchdog.

Test Plan:
- Single fetch read 0x40 in cycle 0 -> rd_req_valid_o=1 with req_is_instr_o=1 in cycle 1; if_resp_valid_o pulses in cycle 12 with memory bytes 0x40..0x4F.
- Both ports request in the same cycle after reset -> data port granted first; fetch port granted the next cycle; req_is_instr_o sequence is 0,1.
- Data write 0x80 = 0xA5 repeated, followed next cycle by a data read of 0x80:
  - write: wr_req_valid_o=1 for one cycle, no data response;
  - read: returns all bytes 0xA5 on dc_resp_data_o.
- Fetch port in WAIT_RESP issues a second request -> if_req_ready_o stays 0 until the cycle of the resp pulse; the second request is accepted in that cycle.
- Inject data_valid_i=1 with data_is_instr_i=0 while the data port is IDLE -> no dc_resp_valid_o; FSMs unchanged.
- With MEM_ARB_TIMEOUT_EN and the memory stubbed silent: fetch read -> timeout_err_o=1 at cycle 32 after entering WAIT_RESP; if_req_ready_o usable again. Assert rst_i mid-wait -> all outputs 0 next cycle.
